// File: rtl/r_format_pkg.sv
// Shared definitions for the R-format execute path: funct3 codes, FSM
// states, shift modes and default widths.
package r_format_pkg;

  localparam int DEFAULT_XLEN    = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_t;

  // funct7[5] is only meaningful for SUB and SRA.
  function automatic logic is_legal(input logic [2:0] f3, input logic b5);
    return !b5 || (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
  endfunction

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/and32.sv
// 32-bit bitwise AND block shared by the execute datapaths.
module and32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign y[gi] = a[gi] & b[gi];
  end

endmodule

// File: rtl/or32.sv
// 32-bit bitwise OR block shared by the execute datapaths.
module or32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign y[gi] = a[gi] | b[gi];
  end

endmodule

// File: rtl/r_shift_step.sv
// Combinational single-bit shifter: SLL fills zero at the LSB, SRL fills
// zero at the MSB, SRA replicates the MSB.
module r_shift_step
  import r_format_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  logic fill_msb;
  assign fill_msb = (mode == SH_SRA) ? din[XLEN-1] : 1'b0;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
    logic left_bit;
    logic right_bit;
    if (gi == 0) begin : g_lsb
      assign left_bit = 1'b0;
    end else begin : g_lmid
      assign left_bit = din[gi-1];
    end
    if (gi == XLEN - 1) begin : g_msb
      assign right_bit = fill_msb;
    end else begin : g_rmid
      assign right_bit = din[gi+1];
    end
    assign dout[gi] = (mode == SH_SLL) ? left_bit : right_bit;
  end

endmodule

// File: rtl/r_format_exec_unit.sv
// Sequential execute responder for RV32I R-format ops: single-cycle
// logic/arithmetic, shifts iterated one bit per cycle, valid/ready both sides.
module r_format_exec_unit
  import r_format_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  state_t            state_reg,   state_next;
  logic [XLEN-1:0]   work_reg,    work_next;
  logic [SHAMT_W-1:0] count_reg,  count_next;
  shift_mode_t       mode_reg,    mode_next;
  logic              illegal_reg, illegal_next;

  logic [XLEN-1:0]    and_y;
  logic [XLEN-1:0]    or_y;
  logic [XLEN-1:0]    shift_y;
  logic [XLEN-1:0]    alu_y;
  logic [SHAMT_W-1:0] shamt;
  logic               legal;

  assign shamt = Y[SHAMT_W-1:0];
  assign legal = is_legal(funct3, funct7_b5);

  and32 u_and (
    .a (X),
    .b (Y),
    .y (and_y)
  );

  or32 u_or (
    .a (X),
    .b (Y),
    .y (or_y)
  );

  r_shift_step #(
    .XLEN (XLEN)
  ) u_shift (
    .mode (mode_reg),
    .din  (work_reg),
    .dout (shift_y)
  );

  // Single-cycle result; shifts start from X and are finished in ST_SHIFT.
  always_comb begin
    alu_y = '0;
    case (funct3)
      F3_ADD_SUB: alu_y = funct7_b5 ? (X - Y) : (X + Y);
      F3_SLL:     alu_y = X;
      F3_SLT:     alu_y = {{(XLEN-1){1'b0}}, ($signed(X) < $signed(Y))};
      F3_SLTU:    alu_y = {{(XLEN-1){1'b0}}, (X < Y)};
      F3_XOR:     alu_y = X ^ Y;
      F3_SRL_SRA: alu_y = X;
      F3_OR:      alu_y = or_y;
      F3_AND:     alu_y = and_y;
      default:    alu_y = '0;
    endcase
    if (!legal) begin
      alu_y = '0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    work_next    = work_reg;
    count_next   = count_reg;
    mode_next    = mode_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          work_next    = alu_y;
          illegal_next = !legal;
          if (funct3 == F3_SLL) begin
            mode_next = SH_SLL;
          end else if (funct7_b5) begin
            mode_next = SH_SRA;
          end else begin
            mode_next = SH_SRL;
          end
          if (legal && is_shift(funct3) && (shamt != '0)) begin
            count_next = shamt;
            state_next = ST_SHIFT;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_next  = shift_y;
        count_next = count_reg - 1'b1;
        if (count_reg == SHAMT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      work_reg    <= '0;
      count_reg   <= '0;
      mode_reg    <= SH_SLL;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      work_reg    <= work_next;
      count_reg   <= count_next;
      mode_reg    <= mode_next;
      illegal_reg <= illegal_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = work_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_r_format_exec_unit.sv
// Randomised and directed bench for r_format_exec_unit with a behavioural
// reference model and one per-cycle compare process.
module tb_r_format_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_b5 = 1'b0;
  logic [31:0] X = 32'd0;
  logic [31:0] Y = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        illegal;

  always #5 clk = ~clk;

  r_format_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfers = 0;
  bit busy = 0;
  bit started = 0;
  bit hold_off = 0;
  int acc_cyc = 0;
  logic [31:0] exp_res = 0, pend_res = 0;
  logic        exp_ill = 0, pend_ill = 0;
  int          exp_lat = 1, pend_lat = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: what the op must return and how many cycles until out_valid.
  function automatic void model(input logic [2:0] f3, input logic b5,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    logic signed [31:0] sx;
    sh  = int'(y[4:0]);
    sx  = x;
    r   = 32'd0;
    ill = 1'b0;
    lat = 1;
    if (b5 && f3 != 3'd0 && f3 != 3'd5) begin
      ill = 1'b1;
    end else begin
      case (f3)
        3'd0: r = b5 ? x - y : x + y;
        3'd1: begin r = x << sh; lat = (sh == 0) ? 1 : sh + 1; end
        3'd2: r = (sx < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: r = (x < y) ? 32'd1 : 32'd0;
        3'd4: r = x ^ y;
        3'd5: begin
          r = b5 ? 32'(sx >>> sh) : (x >> sh);
          lat = (sh == 0) ? 1 : sh + 1;
        end
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end
  endfunction

  // Model bookkeeping on the active edge, using pre-edge values.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy = 0;
    end else if (!busy && in_valid) begin
      busy    = 1;
      acc_cyc = cyc + 1;
      exp_res = pend_res;
      exp_ill = pend_ill;
      exp_lat = pend_lat;
    end else if (busy && (cyc - acc_cyc >= exp_lat - 1) && out_ready) begin
      busy = 0;
      xfers++;
      $display("xfer %0d: result=%h illegal=%b latency=%0d", xfers, exp_res, exp_ill, exp_lat);
    end
    cyc++;
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      if (!rst_n) begin
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
      end else begin
        logic ev;
        ev = busy && (cyc - acc_cyc >= exp_lat - 1);
        chk1("in_ready", in_ready, !busy);
        chk1("out_valid", out_valid, ev);
        if (ev) begin
          chk("result", result, exp_res);
          chk1("illegal", illegal, exp_ill);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [2:0] f3, input logic b5, input logic [31:0] x,
                       input logic [31:0] y, input bit pin, input logic [31:0] pres,
                       input logic pill, input int plat);
    logic [31:0] r;
    logic        il;
    int          lt;
    int          waitc;
    model(f3, b5, x, y, r, il, lt);
    if (pin) begin
      chk("pin_result", r, pres);
      chk1("pin_illegal", il, pill);
      chk("pin_latency", 32'(lt), 32'(plat));
    end
    waitc = 0;
    @(negedge clk);
    while (busy) begin
      in_valid  = 1'($urandom);
      funct3    = 3'($urandom);
      funct7_b5 = 1'($urandom);
      X         = $urandom;
      Y         = $urandom;
      waitc++;
      if (waitc > 300) begin
        chk1("accept_timeout", 1'b1, 1'b0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    pend_res  = r;
    pend_ill  = il;
    pend_lat  = lt;
    funct3    = f3;
    funct7_b5 = b5;
    X         = x;
    Y         = y;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    X        = $urandom;
    Y        = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    logic [31:0] ry;
    #1;
    started = 1;
    chk("rst_result", result, 32'd0);
    chk1("rst_illegal", illegal, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    issue(3'd0, 1'b0, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1'b0, 1);
    issue(3'd0, 1'b1, 32'h0, 32'h1, 1, 32'hFFFFFFFF, 1'b0, 1);
    issue(3'd6, 1'b0, 32'h55555555, 32'hAAAAAAAA, 1, 32'hFFFFFFFF, 1'b0, 1);
    issue(3'd5, 1'b1, 32'h80000000, 32'd31, 1, 32'hFFFFFFFF, 1'b0, 32);
    issue(3'd5, 1'b0, 32'h80000000, 32'd31, 1, 32'h1, 1'b0, 32);
    issue(3'd1, 1'b0, 32'h1, 32'h0, 1, 32'h1, 1'b0, 1);
    issue(3'd2, 1'b0, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 1'b0, 1);
    issue(3'd3, 1'b0, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1'b0, 1);
    issue(3'd6, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1, 32'h0, 1'b1, 1);
    issue(3'd4, 1'b0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1, 32'hF0F0F0F0, 1'b0, 1);
    issue(3'd1, 1'b0, 32'h00000003, 32'd4, 1, 32'h00000030, 1'b0, 5);

    // Backpressure: result must hold while the consumer stalls.
    drain();
    hold_off = 1;
    @(negedge clk);
    issue(3'd7, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 1'b0, 1);
    repeat (10) @(negedge clk);
    x0 = xfers;
    hold_off = 0;
    drain();
    repeat (3) @(negedge clk);
    chk("one_transfer", 32'(xfers - x0), 32'd1);

    // Reset in the middle of a long shift aborts it without a result.
    drain();
    issue(3'd1, 1'b0, 32'h1, 32'd20, 0, 32'h0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    busy = 0;
    #1;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_out_valid", out_valid, 1'b0);
    x0 = xfers;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_xfer", 32'(xfers - x0), 32'd0);

    for (int i = 0; i < 300; i++) begin
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry[4:0] = 5'd0;
      issue(3'($urandom), ($urandom_range(0, 3) == 0), $urandom, ry, 0, 32'h0, 1'b0, 0);
    end
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_format_exec_unit.md
Name: r_format_exec_unit

Overview:
- Sequential execute responder for R-format RV32I ops; the receiving end of the X/Y/result operand interface the R-format modules use.
- Accepts one operand pair plus funct3/funct7[5] via valid/ready, computes, and returns `result` via valid/ready.
- Logic/arith ops complete in 1 cycle; shifts iterate one bit per cycle.
- Sits between decode/regfile read and writeback in the multi-cycle datapath.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (log2 XLEN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- funct3  in  3  RV32I funct3
- funct7_b5  in  1  funct7 bit 5 (SUB/SRA select)
- X  in  XLEN  rs1 operand
- Y  in  XLEN  rs2 operand; Y[4:0] is shamt for shifts
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  computed value
- illegal  out  1  qualifies out_valid: unsupported funct combination

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, result=0, illegal=0, internal shift count=0. Reset mid-operation aborts it silently; no result is emitted.
- FSM states IDLE, SHIFT, DONE. in_ready = (state==IDLE) only; requests are never overlapped.
- IDLE, accept when in_valid&in_ready; latch X, Y[4:0], funct3, funct7_b5.
  - Non-shift: compute and go to DONE. out_valid rises the cycle after acceptance (latency 1).
  - Shift (funct3=001 SLL, 101 SRL/SRA) with shamt=0: result=X, go to DONE (latency 1).
  - Shift with shamt=n>0: go to SHIFT with count=n.
- SHIFT: each cycle shift the working register by 1 (SLL: zero fill at LSB; SRL: zero fill at MSB; SRA: replicate bit 31) and decrement count. When count reaches 1 the final shift is taken and the next state is DONE. out_valid rises 1+n cycles after acceptance (31 max shift → 32 cycles).
- Op map:
  - 000/0 ADD, 000/1 SUB, 001/0 SLL, 010/0 SLT (signed), 011/0 SLTU, 100/0 XOR, 101/0 SRL, 101/1 SRA, 110/0 OR, 111/0 AND.
  - Arithmetic is mod 2^32 with overflow ignored.
  - SLT/SLTU produce 32'h1 or 32'h0.
  - Any other funct7_b5=1 combination: result=0, illegal=1, latency 1.
- DONE: out_valid=1. result and illegal are held stable while out_ready=0. On out_valid&out_ready go to IDLE; out_valid drops the next cycle and in_ready rises the same edge. There is no same-cycle accept of a new request in DONE.
- in_valid may be held with changing data while in_ready=0; the unit ignores it. Only the data present at the accept edge is used.

Decomposition:
- Shared package r_format_pkg:
  - funct3 constants (F3_ADD_SUB, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SRL_SRA, F3_OR, F3_AND).
  - State encoding (ST_IDLE, ST_SHIFT, ST_DONE).
  - XLEN default.
- One sub-module, r_shift_step: combinational 1-bit shift with mode input (SLL/SRL/SRA). It is instantiated once inside the unit.
- Logic ops reuse the team's existing and32/or32 blocks.

Test Plan:
- Reset: rst_n low mid-SHIFT (SLL, shamt=20, after 5 cycles) → out_valid=0, in_ready=1 immediately. No result after release.
- ADD X=32'hFFFFFFFF Y=32'h1 → result 32'h0 one cycle after accept. SUB X=0 Y=1 → 32'hFFFFFFFF. OR X=32'h55555555 Y=32'hAAAAAAAA → 32'hFFFFFFFF.
- SRA X=32'h80000000 Y=31 → result 32'hFFFFFFFF with out_valid 32 cycles after accept. SRL same operands → 32'h1. SLL X=1 Y=0 → 32'h1 at latency 1.
- SLT X=32'hFFFFFFFF Y=1 → 1. SLTU same operands → 0.
- Backpressure: out_ready=0 for 10 cycles after AND X=32'hF0F0F0F0 Y=32'hFF00FF00 → result 32'hF000F000 held stable, in_ready=0 throughout. Release → one transfer only.
- Illegal: funct3=110, funct7_b5=1 → illegal=1, result=0, latency 1. The next legal op returns illegal=0.
